// File: rtl/fetch_pkg.sv
// Shared types and constants for the PPU instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned FETCH_ADDR_W = 32;
    localparam int unsigned FETCH_DATA_W = 32;

    localparam logic [FETCH_ADDR_W-1:0] PC_STEP          = 32'd4;
    localparam logic [FETCH_ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_t;

    // One IF->ID buffer entry: the fetch address and the word found there.
    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Shift-style IF->ID buffer. Slot 0 is always the oldest entry, so the head
// presented to ID comes straight from a register. Supports push, pop, a purge
// that keeps only the oldest surviving entry (delay slot), and a full clear.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               push,
    input  fetch_entry_t       push_entry,
    input  logic               pop,
    input  logic               purge_keep_oldest,
    input  logic               clear,
    output fetch_entry_t       head,
    output logic [CNT_W-1:0]   count
);

    fetch_entry_t     entries_q [DEPTH];
    fetch_entry_t     entries_d [DEPTH];
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] kept;

    // Next contents: pop shifts toward slot 0, purge trims to one, push appends.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        entries_d = entries_q;
        kept      = count;
        if (pop && (count != '0)) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                entries_d[i] = entries_q[i + 1];
            end
            kept = count - CNT_W'(1);
        end
        if (purge_keep_oldest && (kept > CNT_W'(1))) begin
            kept = CNT_W'(1);
        end
        count_d = kept;
        if (push && (kept < CNT_W'(DEPTH))) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (CNT_W'(i) == kept) begin
                    entries_d[i] = push_entry;
                end
            end
            count_d = kept + CNT_W'(1);
        end
        if (clear) begin
            count_d = '0;
        end
    end

    // Payload storage.
    // NOTE: the payload array has no reset; count alone says which slots are valid, so clearing the data would only cost reset fan-out.
    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

    // Occupancy, the only state that must be clean after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else begin
            count <= count_d;
        end
    end

    assign head = entries_q[0];

endmodule

// File: rtl/instr_fetch_stage.sv
// IF stage of the PPU pipeline: PC/nPC tracking with MIPS delay-slot
// semantics, one outstanding instruction-memory request, and a small
// IF->ID buffer (fetch_fifo).
// Optional build macro FETCH_PERF_CNT_EN adds the perf_fetched and
// perf_bubbles counters.
// The buffered entry type is sized by fetch_pkg, so ADDR_W and DATA_W must
// match FETCH_ADDR_W and FETCH_DATA_W.
module instr_fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W     = FETCH_ADDR_W,
    parameter int unsigned       DATA_W     = FETCH_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned       FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [DATA_W-1:0] id_instr,
    output logic [ADDR_W-1:0] id_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              flush_valid,
    input  logic [ADDR_W-1:0] flush_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_bubbles
`endif
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_t      state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] target_pc;
    logic              target_pending;
    logic              drop_rsp;

    logic [CNT_W-1:0]  fifo_count;
    fetch_entry_t      head;
    fetch_entry_t      push_entry;
    logic              pop;
    logic              rsp_arrives;
    logic              slot_in_fifo;
    logic              redirect_take;
    logic              fifo_push;
    logic              room;

    assign pop           = id_valid & id_ready;
    assign rsp_arrives   = (state == WAIT) & imem_rvalid;
    // The branch is the head; a second entry behind it is the delay slot.
    assign slot_in_fifo  = fifo_count >= CNT_W'(2);
    assign redirect_take = redirect_valid & ~flush_valid;
    // Responses younger than a buffered delay slot, or overtaken by a flush, never enter the buffer.
    assign fifo_push     = rsp_arrives & ~drop_rsp & ~flush_valid & ~(redirect_take & slot_in_fifo);
    // Only IDLE issues, so nothing is outstanding when room is evaluated.
    assign room          = fifo_count < CNT_W'(FIFO_DEPTH);

    assign push_entry.pc    = imem_addr;
    assign push_entry.instr = imem_rdata;

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk              (clk),
        .reset_n          (reset_n),
        .push             (fifo_push),
        .push_entry       (push_entry),
        .pop              (pop),
        .purge_keep_oldest(redirect_take),
        .clear            (flush_valid),
        .head             (head),
        .count            (fifo_count)
    );

    assign id_valid = fifo_count != '0;
    assign id_pc    = head.pc;
    assign id_instr = head.instr;

    // Fetch FSM with registered request outputs plus PC, drop and redirect bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            imem_req       <= 1'b0;
            imem_addr      <= RESET_PC;
            fetch_pc       <= RESET_PC;
            target_pc      <= RESET_PC;
            target_pending <= 1'b0;
            drop_rsp       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every branch below read pre-edge state, and a later assignment to the same register overrides an earlier one.
            imem_req <= 1'b0;

            if (rsp_arrives) begin
                drop_rsp <= 1'b0;
            end

            if (flush_valid) begin
                fetch_pc       <= flush_pc;
                target_pending <= 1'b0;
                if ((state == WAIT) && !imem_rvalid) begin
                    drop_rsp <= 1'b1;
                end
            end else if (redirect_valid) begin
                if (slot_in_fifo) begin
                    // Delay slot already buffered: anything in flight is younger.
                    fetch_pc <= redirect_pc;
                    if ((state == WAIT) && !imem_rvalid) begin
                        drop_rsp <= 1'b1;
                    end
                end else if (state == WAIT) begin
                    // The in-flight response is the delay slot; keep it.
                    fetch_pc <= redirect_pc;
                end else begin
                    // Delay slot not requested yet: fetch it, then jump.
                    target_pending <= 1'b1;
                    target_pc      <= redirect_pc;
                end
            end

            unique case (state)
                IDLE: begin
                    if (!flush_valid && !redirect_valid && room) begin
                        state     <= WAIT;
                        imem_req  <= 1'b1;
                        imem_addr <= fetch_pc;
                        if (target_pending) begin
                            fetch_pc       <= target_pc;
                            target_pending <= 1'b0;
                        end else begin
                            fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
                        end
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Wrapping counters of delivered instructions and starved ID cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched <= 32'd0;
            perf_bubbles <= 32'd0;
        end else begin
            if (pop) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (id_ready && !id_valid) begin
                perf_bubbles <= perf_bubbles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: a behavioural instruction memory
// with programmable latency, a scoreboard of expected ID deliveries, a table
// of branch scenarios, and hand sequences for flush, wrap and reset.
module tb_instr_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_valid;
    logic [31:0] flush_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    instr_fetch_stage dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .flush_valid   (flush_valid),
        .flush_pc      (flush_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_bubbles  (perf_bubbles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_checks;
    int          n_fail;
    int          cyc;
    int          lat;
    bit          busy;
    int          cnt;
    logic [31:0] raddr;
    bit          stray_q;
    bit          ready_q;
    logic [31:0] exp_q   [$];
    logic [31:0] req_log [$];
    int          hs_cyc  [$];

    typedef struct {
        int          lat;
        int          hold;
        logic [31:0] br;
        logic [31:0] tgt;
    } rd_vec_t;

    rd_vec_t vecs [5];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: memory model, ID acceptance and scoreboard compare, all
    // evaluated 1 time unit after the rising edge.
    task automatic cycle();
        logic [31:0] e;
        @(posedge clk);
        #1;
        cyc++;
        redirect_valid = 1'b0;
        flush_valid    = 1'b0;
        imem_rvalid    = 1'b0;
        if (stray_q) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
            stray_q     = 1'b0;
        end
        if (busy) begin
            cnt--;
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(raddr);
                busy        = 1'b0;
            end
        end
        if (imem_req) begin
            busy  = 1'b1;
            cnt   = lat;
            raddr = imem_addr;
            req_log.push_back(imem_addr);
        end
        id_ready = ready_q && (exp_q.size() != 0);
        if (id_valid && id_ready) begin
            e = exp_q.pop_front();
            check("id_pc", {32'd0, id_pc}, {32'd0, e});
            check("id_instr", {32'd0, id_instr}, {32'd0, mem_word(e)});
            hs_cyc.push_back(cyc);
        end
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        busy           = 1'b0;
        stray_q        = 1'b0;
        ready_q        = 1'b0;
        imem_rvalid    = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        flush_valid    = 1'b0;
        exp_q.delete();
        req_log.delete();
        hs_cyc.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic drain(input string name, input int budget);
        for (int c = 0; c < budget && exp_q.size() != 0; c++) begin
            cycle();
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int          gap;
        int          bad;
        int          idx;
        bit          seen;
        logic [31:0] nxt;

        n_checks       = 0;
        n_fail         = 0;
        cyc            = 0;
        lat            = 1;
        reset_n        = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'd0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        flush_valid    = 1'b0;
        flush_pc       = 32'd0;
        busy           = 1'b0;
        stray_q        = 1'b0;
        ready_q        = 1'b0;

        vecs[0] = '{1, 0,  32'h10, 32'h40};   // branch case from the plan
        vecs[1] = '{3, 0,  32'h20, 32'h100};  // late delay slot
        vecs[2] = '{1, 10, 32'h0,  32'h80};   // delay slot already buffered
        vecs[3] = '{1, 10, 32'h4,  32'h40};   // delay slot in flight
        vecs[4] = '{2, 4,  32'hC,  32'h200};

        // Reset state while reset is held.
        @(posedge clk);
        #1;
        check("reset_imem_req", imem_req, 0);
        check("reset_imem_addr", imem_addr, RST_PC);
        check("reset_id_valid", id_valid, 0);

        // Streaming: 1-cycle memory, ID always ready, program from 0.
        do_reset();
        lat = 1;
        cycle();
        check("first_req", imem_req, 1);
        check("first_addr", imem_addr, RST_PC);
        for (int a = 0; a < 16; a++) exp_q.push_back(32'(a * 4));
        ready_q = 1'b1;
        drain("stream_drain", 300);
        gap = (hs_cyc.size() >= 2) ? hs_cyc[1] - hs_cyc[0] : 99;
        bad = 0;
        for (int i = 2; i < hs_cyc.size(); i++) begin
            if (hs_cyc[i] - hs_cyc[i-1] != gap) bad++;
        end
        check("stream_cadence_steady", bad, 0);
        check("stream_gap_le_3", (gap <= 3), 1);
`ifdef FETCH_PERF_CNT_EN
        check("stream_perf_fetched", perf_fetched, 16);
`endif

        // Backpressure: ID stalls for 10 cycles, a stray response hits IDLE.
        do_reset();
        lat = 1;
        for (int a = 0; a < 8; a++) exp_q.push_back(32'(a * 4));
        ready_q = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c == 8) stray_q = 1'b1;
            cycle();
        end
        check("bp_req_count", req_log.size(), 2);
        check("bp_id_valid", id_valid, 1);
        check("bp_head_pc", id_pc, 32'h0);
        ready_q = 1'b1;
        drain("bp_drain", 200);

        // Redirect scenarios: ID must see 0..br, br+4, tgt, tgt+4, tgt+8.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            lat = vecs[v].lat;
            for (int a = 0; a <= int'(vecs[v].br); a += 4) exp_q.push_back(32'(a));
            exp_q.push_back(vecs[v].br + 32'd4);
            exp_q.push_back(vecs[v].tgt);
            exp_q.push_back(vecs[v].tgt + 32'd4);
            exp_q.push_back(vecs[v].tgt + 32'd8);
            ready_q = 1'b0;
            repeat (vecs[v].hold) cycle();
            ready_q = 1'b1;
            for (int c = 0; c < 300 && exp_q.size() != 0; c++) begin
                cycle();
                if (id_valid && id_ready && (id_pc == vecs[v].br)) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = vecs[v].tgt;
                end
            end
            check("rd_drain", exp_q.size(), 0);
            idx = -1;
            foreach (req_log[i]) begin
                if (idx < 0 && req_log[i] == vecs[v].br + 32'd4) idx = i;
            end
            nxt = 32'hFFFF_FFFF;
            if (idx >= 0 && idx + 1 < req_log.size()) nxt = req_log[idx + 1];
            check("rd_fetch_after_slot", nxt, vecs[v].tgt);
        end

        // Flush while a 3-cycle response is in flight.
        do_reset();
        lat = 3;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        ready_q = 1'b1;
        drain("fl_pre_drain", 100);
        ready_q = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            cycle();
            seen = imem_req;
        end
        check("fl_req_seen", seen, 1);
        flush_valid = 1'b1;
        flush_pc    = 32'h80;
        cycle();
        check("fl_id_valid_low", id_valid, 0);
        exp_q.push_back(32'h80);
        exp_q.push_back(32'h84);
        exp_q.push_back(32'h88);
        ready_q = 1'b1;
        drain("fl_drain", 100);

        // Flush near the top of the address space: fetch_pc wraps to 0.
        ready_q = 1'b0;
        cycle();
        flush_valid = 1'b1;
        flush_pc    = 32'hFFFF_FFF8;
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        cycle();
        ready_q = 1'b1;
        drain("wrap_drain", 100);

        // Reset asserted in the middle of a WAIT.
        do_reset();
        lat = 3;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        ready_q = 1'b1;
        drain("rst_pre_drain", 100);
        ready_q = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            cycle();
            seen = imem_req;
        end
        check("rst_req_seen", seen, 1);
        cycle();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_imem_req", imem_req, 0);
        check("rst_mid_imem_addr", imem_addr, RST_PC);
        check("rst_mid_id_valid", id_valid, 0);
`ifdef FETCH_PERF_CNT_EN
        check("rst_mid_perf_fetched", perf_fetched, 0);
        check("rst_mid_perf_bubbles", perf_bubbles, 0);
`endif
        busy = 1'b0;
        exp_q.delete();
        req_log.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cycle();
        check("rst_first_req", imem_req, 1);
        check("rst_first_addr", imem_addr, RST_PC);
`ifdef FETCH_PERF_CNT_EN
        check("rst_perf_fetched", perf_fetched, 0);
        check("rst_perf_bubbles", perf_bubbles, 0);
`endif
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        ready_q = 1'b1;
        drain("rst_post_drain", 100);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
